// File: rtl/seg_scan_ctrl.sv
// Multiplexed 8-digit seven-segment scanner for the dice game: shows both dice and a status word.
// Optional `SEG_BLINK_EN: blinks the dice digits while a re-roll is pending.
module seg_scan_ctrl #(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       Win,
    input  logic       Lose,
    input  logic       Roll,
    input  logic [2:0] Dice1,
    input  logic [2:0] Dice2,
    output logic [7:0] Anode,
    output logic [6:0] Cathode
);

    localparam int unsigned CntW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(REFRESH_DIV - 1);

    localparam logic [6:0] SegBlank = 7'h7F;
    localparam logic [6:0] SegDash  = 7'h3F;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      dig_q, dig_d;
    logic [7:0]      anode_q, anode_d;
    logic [6:0]      cathode_q, cathode_d;
    logic            tick;
    logic            blank_dice;
    logic [6:0]      glyph;

    function automatic logic [6:0] die_glyph(input logic [2:0] v);
        logic [6:0] g;
        case (v)
            3'd1:    g = 7'h79;
            3'd2:    g = 7'h24;
            3'd3:    g = 7'h30;
            3'd4:    g = 7'h19;
            3'd5:    g = 7'h12;
            3'd6:    g = 7'h02;
            default: g = SegDash;
        endcase
        return g;
    endfunction

    // pos 3 is the leftmost status digit (digit 7).
    function automatic logic [6:0] status_glyph(input logic w, input logic l, input logic r,
                                                input logic [1:0] pos);
        logic [6:0] g;
        g = SegBlank;
        if (w) begin
            case (pos)
                2'd3:    g = 7'h0C;
                2'd2:    g = 7'h08;
                default: g = 7'h12;
            endcase
        end else if (l) begin
            case (pos)
                2'd3:    g = 7'h47;
                2'd2:    g = 7'h40;
                2'd1:    g = 7'h12;
                default: g = 7'h06;
            endcase
        end else if (r) begin
            case (pos)
                2'd3:    g = 7'h2F;
                2'd2:    g = 7'h23;
                default: g = 7'h47;
            endcase
        end
        return g;
    endfunction

    assign tick = (cnt_q == CntLast);

`ifdef SEG_BLINK_EN
    logic [8:0] blink_q, blink_d;

    always_comb begin
        blink_d = blink_q;
        if (tick) begin
            blink_d = blink_q + 9'd1;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            blink_q <= '0;
        end else begin
            blink_q <= blink_d;
        end
    end

    assign blank_dice = Roll & ~Win & ~Lose & blink_q[8];
`else
    assign blank_dice = 1'b0;
`endif

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        dig_d = tick ? dig_q + 3'd1 : dig_q;
    end

    always_comb begin
        glyph = SegBlank;
        case (dig_d)
            3'd0:       glyph = blank_dice ? SegBlank : die_glyph(Dice2);
            3'd1:       glyph = blank_dice ? SegBlank : die_glyph(Dice1);
            3'd2, 3'd3: glyph = SegBlank;
            default:    glyph = status_glyph(Win, Lose, Roll, dig_d[1:0]);
        endcase
    end

    // Outputs are registered from the next-state values so they line up with cnt/dig.
    always_comb begin
        anode_d   = (32'(cnt_d) < BLANK_CYCLES) ? 8'hFF : ~(8'b1 << dig_d);
        cathode_d = tick ? glyph : cathode_q;
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            dig_q     <= '0;
            anode_q   <= 8'hFF;
            cathode_q <= SegBlank;
        end else begin
            cnt_q     <= cnt_d;
            dig_q     <= dig_d;
            anode_q   <= anode_d;
            cathode_q <= cathode_d;
        end
    end

    assign Anode   = anode_q;
    assign Cathode = cathode_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized bench for seg_scan_ctrl against a slot-arithmetic reference model.
// Define SEG_BLINK_EN for both files to cover the blink option.
module tb_seg_scan_ctrl;

    localparam int unsigned R = 4;
    localparam int unsigned B = 1;

    logic       CLK = 1'b0;
    logic       reset;
    logic       Win, Lose, Roll;
    logic [2:0] Dice1, Dice2;
    logic [7:0] Anode;
    logic [6:0] Cathode;

    seg_scan_ctrl #(
        .REFRESH_DIV (R),
        .BLANK_CYCLES(B)
    ) dut (
        .CLK    (CLK),
        .reset  (reset),
        .Win    (Win),
        .Lose   (Lose),
        .Roll   (Roll),
        .Dice1  (Dice1),
        .Dice2  (Dice2),
        .Anode  (Anode),
        .Cathode(Cathode)
    );

    always #5 CLK = ~CLK;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Model state: edges since reset release, and the glyph latched at the last slot start.
    int unsigned n = 0;
    logic [6:0]  exp_cat = 7'h7F;

    logic [6:0] dice_tab [0:7] = '{7'h3F, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h3F};
    logic [6:0] pass_w [0:3] = '{7'h0C, 7'h08, 7'h12, 7'h12};
    logic [6:0] lose_w [0:3] = '{7'h47, 7'h40, 7'h12, 7'h06};
    logic [6:0] roll_w [0:3] = '{7'h2F, 7'h23, 7'h47, 7'h47};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at t=%0t edge=%0d: got %0h expected %0h", tag, $time, n, got, exp);
        end
    endtask

    // Glyph for slot number k (k-th slot since reset, k >= 1).
    function automatic logic [6:0] ref_glyph(input int unsigned k);
        int unsigned d;
        bit          blank;
        d     = k % 8;
        blank = 1'b0;
`ifdef SEG_BLINK_EN
        blank = Roll && !Win && !Lose && ((((k - 1) % 512) / 256) == 1);
`endif
        if (d == 0) return blank ? 7'h7F : dice_tab[Dice2];
        if (d == 1) return blank ? 7'h7F : dice_tab[Dice1];
        if (d < 4) return 7'h7F;
        if (Win) return pass_w[7 - d];
        if (Lose) return lose_w[7 - d];
        if (Roll) return roll_w[7 - d];
        return 7'h7F;
    endfunction

    function automatic logic [7:0] ref_anode();
        if ((n % R) < B) return 8'hFF;
        return ~(8'd1 << ((n / R) % 8));
    endfunction

    task automatic run(input int unsigned cycles);
        for (int i = 0; i < int'(cycles); i++) begin
            @(posedge CLK);
            n++;
            if (n % R == 0) exp_cat = ref_glyph(n / R);
            @(negedge CLK);
            check_eq("anode", 32'(Anode), 32'(ref_anode()));
            check_eq("cathode", 32'(Cathode), 32'(exp_cat));
        end
    endtask

    task automatic set_in(input logic w, input logic l, input logic r,
                          input logic [2:0] d1, input logic [2:0] d2);
        Win = w; Lose = l; Roll = r; Dice1 = d1; Dice2 = d2;
    endtask

    initial begin
        reset = 1'b1;
        set_in(0, 0, 0, 3'd1, 3'd1);
        repeat (2) @(negedge CLK);
        check_eq("rst_anode", 32'(Anode), 32'hFF);
        check_eq("rst_cathode", 32'(Cathode), 32'h7F);
        reset = 1'b0;
        n = 0;
        exp_cat = 7'h7F;

        // Scan sequence and digit wrap.
        run(40);
        set_in(0, 0, 0, 3'd4, 3'd2);
        run(40);
        set_in(0, 0, 0, 3'd0, 3'd7);
        run(40);
        set_in(1, 1, 0, 3'd5, 3'd6);
        run(40);
        set_in(0, 1, 1, 3'd5, 3'd6);
        run(40);

        // Change Dice2 at cnt=2 of a digit-0 slot.
        set_in(0, 0, 0, 3'd3, 3'd1);
        run(32);
        for (int i = 0; i < 64 && (n % 32) != 2; i++) run(1);
        check_eq("align_dig0", 32'(n % 32), 32'd2);
        check_eq("mid_hold_pre", 32'(Cathode), 32'h79);
        Dice2 = 3'd6;
        run(1);
        check_eq("mid_hold", 32'(Cathode), 32'h79);
        run(40);

        // Async reset between edges at cnt=2 of an active slot.
        for (int i = 0; i < 8 && (n % R) != 2; i++) run(1);
        check_eq("pre_rst_anode_on", 32'(Anode == 8'hFF), 32'd0);
        reset = 1'b1;
        #1;
        check_eq("async_anode", 32'(Anode), 32'hFF);
        check_eq("async_cathode", 32'(Cathode), 32'h7F);
        repeat (2) @(negedge CLK);
        check_eq("hold_anode", 32'(Anode), 32'hFF);
        check_eq("hold_cathode", 32'(Cathode), 32'h7F);
        reset = 1'b0;
        n = 0;
        exp_cat = 7'h7F;
        run(8);

        // Randomized inputs, changing at arbitrary points within slots.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(5) == 0) begin
                set_in(1'($urandom_range(3) == 0), 1'($urandom_range(3) == 0),
                       1'($urandom_range(1)), 3'($urandom_range(7)), 3'($urandom_range(7)));
            end
            run(1);
        end

`ifdef SEG_BLINK_EN
        set_in(0, 0, 1, 3'd3, 3'd5);
        run(R * 1100);
        set_in(1, 0, 1, 3'd3, 3'd5);
        run(R * 600);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
